// File: rtl/pipeline_stage_pkg.sv
// Shared types for the pipeline skid-buffer stage: occupancy state encoding
// and the occupancy port width.
package pipeline_stage_pkg;

   localparam int OCC_W = 2;

   typedef enum logic [OCC_W-1:0] {
      EMPTY = 2'd0,
      HALF  = 2'd1,
      FULL  = 2'd2
   } stage_state_e;

   // Number of payloads held in each state; the encoding is chosen so this is
   // a plain cast, but the function keeps callers independent of that choice.
   function automatic logic [OCC_W-1:0] occupancy_of(input stage_state_e s);
      logic [OCC_W-1:0] occ;
      case (s)
         HALF:    occ = 2'd1;
         FULL:    occ = 2'd2;
         default: occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/pipeline_stage_reg.sv
// Two-entry (main + skid) pipeline stage register with ready/valid handshake
// and flush. Optional stall counter enabled by defining PIPE_STAGE_PERF_EN.
module pipeline_stage_reg
   import pipeline_stage_pkg::*;
#(
   parameter int               WIDTH     = 64,
   parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   input  logic             flush,
   output logic [OCC_W-1:0] occupancy
`ifdef PIPE_STAGE_PERF_EN
   ,
   output logic [31:0]      stall_cycles
`endif
);

   stage_state_e     state_q, state_d;
   logic [WIDTH-1:0] main_q, main_d;
   logic [WIDTH-1:0] skid_q, skid_d;
   logic             in_fire;
   logic             out_fire;

   // in_ready depends only on registered state, so no combinational path
   // runs from out_ready back to the upstream stage.
   assign in_ready  = (state_q != FULL);
   assign out_valid = (state_q != EMPTY);
   assign out_data  = main_q;
   assign occupancy = occupancy_of(state_q);

   assign in_fire  = in_valid && in_ready;
   assign out_fire = out_valid && out_ready;

   // NOTE: every target gets a default before the case, so no path leaves a
   // signal unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;

      if (flush) begin
         state_d = EMPTY;
         main_d  = FLUSH_VAL;
         skid_d  = FLUSH_VAL;
      end else begin
         case (state_q)
            EMPTY: begin
               if (in_fire) begin
                  state_d = HALF;
                  main_d  = in_data;
               end
            end
            HALF: begin
               if (in_fire && out_fire) begin
                  main_d = in_data;
               end else if (out_fire) begin
                  state_d = EMPTY;
               end else if (in_fire) begin
                  state_d = FULL;
                  skid_d  = in_data;
               end
            end
            FULL: begin
               if (out_fire) begin
                  state_d = HALF;
                  main_d  = skid_q;
               end
            end
            default: begin
               state_d = EMPTY;
               main_d  = FLUSH_VAL;
               skid_d  = FLUSH_VAL;
            end
         endcase
      end
   end

   // NOTE: the payload registers are reset to FLUSH_VAL as well as the state,
   // so out_data is deterministic straight out of reset; this is a two-entry
   // register, not a RAM, so the reset costs nothing worth avoiding.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         // NOTE: non-blocking assignments for all sequential state, so every
         // register samples the pre-edge values regardless of statement order.
         state_q <= EMPTY;
         main_q  <= FLUSH_VAL;
         skid_q  <= FLUSH_VAL;
      end else begin
         state_q <= state_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_q;

   // Counts backpressure cycles; flush deliberately leaves it alone.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         stall_q <= '0;
      end else if (out_valid && !out_ready && (stall_q != 32'hFFFF_FFFF)) begin
         stall_q <= stall_q + 32'd1;
      end
   end

   assign stall_cycles = stall_q;
`endif

endmodule

// File: tb/tb_pipeline_stage_reg.sv
// Directed + random bench for pipeline_stage_reg: a queue scoreboard holds the
// payloads the stage should be holding, checked every cycle with assertions.
module tb_pipeline_stage_reg;
   import pipeline_stage_pkg::*;

   localparam int          WIDTH = 64;
   localparam logic [63:0] FV    = 64'hDEAD_BEEF_C0DE_F1F1;

   logic             CLK;
   logic             nRST;
   logic             in_valid;
   logic [WIDTH-1:0] in_data;
   logic             in_ready;
   logic             out_valid;
   logic [WIDTH-1:0] out_data;
   logic             out_ready;
   logic             flush;
   logic [OCC_W-1:0] occupancy;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]      stall_cycles;
`endif

   pipeline_stage_reg #(
      .WIDTH     (WIDTH),
      .FLUSH_VAL (FV)
   ) dut (
      .CLK          (CLK),
      .nRST         (nRST),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_data     (out_data),
      .out_ready    (out_ready),
      .flush        (flush),
      .occupancy    (occupancy)
`ifdef PIPE_STAGE_PERF_EN
      ,
      .stall_cycles (stall_cycles)
`endif
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb[$];
   int          m_occ = 0;
   logic [31:0] m_stall = '0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_state();
      check("in_ready",  64'(in_ready),  64'(m_occ != 2));
      check("out_valid", 64'(out_valid), 64'(m_occ != 0));
      check("occupancy", 64'(occupancy), 64'(m_occ));
      if (m_occ != 0) check("out_data", out_data, sb[0]);
`ifdef PIPE_STAGE_PERF_EN
      check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
`endif
   endtask

   // One clock cycle: drive, check against the model, advance the model.
   task automatic step(input logic iv, input logic [63:0] d, input logic ordy, input logic fl);
      logic in_f, out_f;
      in_valid  = iv;
      in_data   = d;
      out_ready = ordy;
      flush     = fl;
      #1;
      check_state();
      in_f  = iv && (m_occ != 2);
      out_f = (m_occ != 0) && ordy;
      if ((m_occ != 0) && !ordy && (m_stall != 32'hFFFF_FFFF)) m_stall++;
      if (fl) begin
         sb.delete();
      end else begin
         if (out_f) void'(sb.pop_front());
         if (in_f) sb.push_back(d);
      end
      m_occ = sb.size();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      nRST      = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      flush     = 1'b0;
      @(negedge CLK);
      @(negedge CLK);
      #1;
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_in_ready",  64'(in_ready),  64'd1);
      check("rst_occupancy", 64'(occupancy), 64'd0);
      check("rst_out_data",  out_data,       FV);
`ifdef PIPE_STAGE_PERF_EN
      check("rst_stall", 64'(stall_cycles), 64'd0);
`endif
      nRST = 1'b1;

      // Single payload, one-cycle latency.
      step(1'b1, 64'hA5, 1'b1, 1'b0);
      #1;
      check("t1_valid", 64'(out_valid), 64'd1);
      check("t1_data",  out_data,       64'hA5);
      check("t1_occ",   64'(occupancy), 64'd1);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Backpressure fills the skid; order preserved on release.
      step(1'b1, 64'h1, 1'b0, 1'b0);
      step(1'b1, 64'h2, 1'b0, 1'b0);
      #1;
      check("full_occ",      64'(occupancy), 64'd2);
      check("full_in_ready", 64'(in_ready),  64'd0);
      check("full_data",     out_data,       64'h1);
      step(1'b1, 64'h3, 1'b0, 1'b0);
      step(1'b0, 64'h0, 1'b0, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);
      #1;
      check("drain_first", out_data, 64'h2);
      step(1'b0, 64'h0, 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Full-throughput stream of 100 payloads.
      for (int i = 0; i < 100; i++) step(1'b1, 64'h100 + 64'(i) * 64'h0101_0101, 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);
      check("stream_drained", 64'(out_valid), 64'd0);

      // Random handshake traffic.
      for (int i = 0; i < 80; i++)
         step(1'($urandom_range(0, 1)), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Flush from HALF overrides a simultaneous in and out transfer.
      step(1'b1, 64'h11, 1'b0, 1'b0);
      step(1'b1, 64'h22, 1'b1, 1'b1);
      #1;
      check("flush_half_valid", 64'(out_valid), 64'd0);
      check("flush_half_data",  out_data,       FV);

      // Flush from FULL drops the held payloads and the pending input.
      step(1'b1, 64'h31, 1'b0, 1'b0);
      step(1'b1, 64'h32, 1'b0, 1'b0);
      step(1'b1, 64'h33, 1'b0, 1'b1);
      #1;
      check("flush_full_valid", 64'(out_valid), 64'd0);
      check("flush_full_data",  out_data,       FV);
      check("flush_full_occ",   64'(occupancy), 64'd0);
      check("flush_full_rdy",   64'(in_ready),  64'd1);
      step(1'b0, 64'h0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a cycle while FULL.
      step(1'b1, 64'h41, 1'b0, 1'b0);
      step(1'b1, 64'h42, 1'b0, 1'b0);
      in_valid = 1'b0;
      #2;
      nRST = 1'b0;
      #1;
      check("arst_out_valid", 64'(out_valid), 64'd0);
      check("arst_in_ready",  64'(in_ready),  64'd1);
      check("arst_occ",       64'(occupancy), 64'd0);
      check("arst_data",      out_data,       FV);
      sb.delete();
      m_occ   = 0;
      m_stall = '0;
      @(negedge CLK);
      nRST = 1'b1;
      step(1'b1, 64'h51, 1'b1, 1'b0);
      #1;
      check("post_rst_data", out_data, 64'h51);
      step(1'b0, 64'h0, 1'b1, 1'b0);

`ifdef PIPE_STAGE_PERF_EN
      // Stall counter: seven backpressure cycles, then a flush keeps the count.
      step(1'b1, 64'h61, 1'b0, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b0, 64'h0, 1'b0, 1'b0);
      #1;
      check("stall_seven", 64'(stall_cycles), 64'd7);
      step(1'b0, 64'h0, 1'b1, 1'b1);
      #1;
      check("stall_after_flush", 64'(stall_cycles), 64'd7);
`endif

      step(1'b0, 64'h0, 1'b0, 1'b0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
